spi_ram_word_reader: RTL and testbench

// - Upstream of the LED scan stage. Reads one 32-bit word from a serial SPI SRAM (23LC512-class) at a 16-bit byte address.
// - Presents the word on data[31:0]; data[31:24] feeds LED column 1.
// - Top level drives the address and request and consumes data / data_valid.

---
 rtl/spi_ram_pkg.sv | 47 ++++
 rtl/spi_ram_word_reader_sck.sv | 50 +++++
 rtl/spi_ram_word_reader.sv | 156 +++++++++++++++
 tb/tb_spi_ram_word_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared definitions for the SPI SRAM word reader.
//   state_t      - transfer phases of the reader FSM
//   CMD_*        - SPI SRAM read opcodes
//   *_BITS       - bit lengths of each serial phase
//   READ_CMD     - opcode actually issued by this build
//   phase_bits() - bit length of a shifting phase
// Build option: SPI_RAM_FAST_READ_EN selects FAST READ (0x0B) plus a dummy byte.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    HOLD
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam logic [5:0] CMD_BITS   = 6'd8;
  localparam logic [5:0] ADDR_BITS  = 6'd16;
  localparam logic [5:0] DUMMY_BITS = 6'd8;
  localparam logic [5:0] DATA_BITS  = 6'd32;

`ifdef SPI_RAM_FAST_READ_EN
  localparam bit FAST_READ = 1'b1;
`else
  localparam bit FAST_READ = 1'b0;
`endif

  localparam logic [7:0] READ_CMD = FAST_READ ? CMD_FAST_READ : CMD_READ;

  function automatic logic [5:0] phase_bits(input state_t s);
    logic [5:0] n;
    case (s)
      CMD:     n = CMD_BITS;
      ADDR:    n = ADDR_BITS;
      DUMMY:   n = DUMMY_BITS;
      DATA:    n = DATA_BITS;
      default: n = 6'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/spi_ram_word_reader_sck.sv
// spi_sck_gen: SPI mode-0 clock generator for the word reader.
//   clk, rst   - system clock, async active-high reset
//   en         - run the bit clock; when low SCK is held low and the phase restarts
//   sck        - registered SCK (low CLK_DIV cycles, then high CLK_DIV cycles)
//   shift_out  - last cycle of a bit: MOSI advances on this edge as SCK falls
//   sample_in  - cycle in which SCK has just risen: MISO is captured on this edge
//   bit_done   - last cycle of the SCK high phase
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic shift_out,
  output logic sample_in,
  output logic bit_done
);

  localparam int unsigned CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] RISE = CW'(CLK_DIV);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    if (en && (cnt != LAST)) begin
      cnt_next = cnt + CW'(1);
    end
  end

  // SCK is a flop decoded from the next count, so it cannot glitch and is
  // already low in the first cycle after en drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else begin
      cnt <= cnt_next;
      sck <= en && (cnt_next >= RISE);
    end
  end

  assign sample_in = en && (cnt == RISE);
  assign bit_done  = en && (cnt == LAST);
  assign shift_out = en && (cnt == LAST);

endmodule

// File: rtl/spi_ram_word_reader.sv
// spi_ram_word_reader: reads one 32-bit word from a 23LC512-class SPI SRAM.
//   clk12MHz    - system clock
//   rst         - async active-high reset
//   req, addr   - start request and 16-bit byte address (accepted when busy=0)
//   busy        - transfer in progress, including the chip-select hold time
//   data_valid  - one-cycle pulse when data is updated
//   data        - last word read, first received byte in [31:24]
//   spi_select  - chip select, active low
//   spi_clk_out - SCK, mode 0
//   spi_mosi    - serial out, MSB first
//   spi_miso    - serial in
// Build option: SPI_RAM_FAST_READ_EN issues FAST READ with an 8-bit dummy phase.
module spi_ram_word_reader
  import spi_ram_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_HOLD = 4
) (
  input  logic        clk12MHz,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] addr,
  output logic        busy,
  output logic        data_valid,
  output logic [31:0] data,
  output logic        spi_select,
  output logic        spi_clk_out,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned HW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HOLD - 1);

  state_t        state, state_d;
  logic [5:0]    bit_cnt, bit_cnt_d;
  logic [HW-1:0] hold_cnt, hold_cnt_d;
  logic [23:0]   mosi_sr, mosi_sr_d;
  logic [31:0]   miso_sr, miso_sr_d;
  logic [31:0]   data_d;
  logic          data_valid_d;
  logic          select_d;

  logic sck_en;
  logic shift_out;
  logic sample_in;
  logic bit_done;

  assign sck_en = (state != IDLE) && (state != HOLD);
  assign busy   = (state != IDLE);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck (
    .clk      (clk12MHz),
    .rst      (rst),
    .en       (sck_en),
    .sck      (spi_clk_out),
    .shift_out(shift_out),
    .sample_in(sample_in),
    .bit_done (bit_done)
  );

  // MOSI is the MSB of the command/address shifter; zeros shift in behind it,
  // so the line is low for the dummy and data phases.
  assign spi_mosi = mosi_sr[23];

  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      mosi_sr    <= '0;
      miso_sr    <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      spi_select <= 1'b1;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      hold_cnt   <= hold_cnt_d;
      mosi_sr    <= mosi_sr_d;
      miso_sr    <= miso_sr_d;
      data       <= data_d;
      data_valid <= data_valid_d;
      spi_select <= select_d;
    end
  end

  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    hold_cnt_d   = hold_cnt;
    mosi_sr_d    = mosi_sr;
    miso_sr_d    = miso_sr;
    data_d       = data;
    data_valid_d = 1'b0;
    select_d     = spi_select;

    case (state)
      IDLE: begin
        if (req) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          mosi_sr_d = {READ_CMD, addr};
          select_d  = 1'b0;
        end
      end

      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt + HW'(1);
        end
      end

      default: begin
        if (shift_out) begin
          mosi_sr_d = mosi_sr << 1;
        end
        if (sample_in && (state == DATA)) begin
          miso_sr_d = (miso_sr << 1) | 32'(spi_miso);
        end
        if (bit_done) begin
          if (bit_cnt == (phase_bits(state) - 6'd1)) begin
            bit_cnt_d = '0;
            case (state)
              CMD:   state_d = ADDR;
`ifdef SPI_RAM_FAST_READ_EN
              ADDR:  state_d = DUMMY;
              DUMMY: state_d = DATA;
`else
              ADDR:  state_d = DATA;
`endif
              DATA:  state_d = HOLD;
              default: state_d = IDLE;
            endcase
            // With CLK_DIV=1 the last sample and the end of the bit share a
            // cycle, hence the copy from the updated shifter.
            if (state == DATA) begin
              data_d       = miso_sr_d;
              data_valid_d = 1'b1;
              select_d     = 1'b1;
              hold_cnt_d   = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt + 6'd1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_spi_ram_word_reader.sv
// Testbench for spi_ram_word_reader with a behavioural 23LC512-style SPI SRAM.
module tb_spi_ram_word_reader;

`ifdef SPI_RAM_FAST_READ_EN
  localparam logic [7:0] EXP_CMD   = 8'h0B;
  localparam int         EXP_DV    = 257;
  localparam int         EXP_RISES = 64;
  localparam int         DATA_START = 32;
`else
  localparam logic [7:0] EXP_CMD   = 8'h03;
  localparam int         EXP_DV    = 225;
  localparam int         EXP_RISES = 56;
  localparam int         DATA_START = 24;
`endif
  localparam int EXP_FALL = EXP_DV + 4;

  logic        clk12MHz = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [15:0] addr = '0;
  logic        busy;
  logic        data_valid;
  logic [31:0] data;
  logic        spi_select;
  logic        spi_clk_out;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  always #5 clk12MHz = ~clk12MHz;

  spi_ram_word_reader #(
    .CLK_DIV(2),
    .CS_HOLD(4)
  ) dut (
    .clk12MHz   (clk12MHz),
    .rst        (rst),
    .req        (req),
    .addr       (addr),
    .busy       (busy),
    .data_valid (data_valid),
    .data       (data),
    .spi_select (spi_select),
    .spi_clk_out(spi_clk_out),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  // ---------------- SPI SRAM model (mode 0, sequential read) ----------------
  logic [7:0]  mem [0:65535];
  int          m_cnt = 0;
  logic [23:0] m_in = '0;
  logic [7:0]  m_cmd = '0;
  logic [15:0] m_addr = '0;

  always @(negedge spi_select) m_cnt = 0;

  always @(posedge spi_clk_out) begin
    if (!spi_select) begin
      m_in = {m_in[22:0], spi_mosi};
      m_cnt++;
      if (m_cnt == 24) begin
        m_cmd  = m_in[23:16];
        m_addr = m_in[15:0];
      end
    end
  end

  always @(negedge spi_clk_out) begin
    int          idx;
    logic [15:0] p;
    logic [7:0]  b;
    if (!spi_select && m_cnt >= DATA_START) begin
      idx      = m_cnt - DATA_START;
      p        = m_addr + 16'(idx / 8);
      b        = mem[p];
      spi_miso = b[7 - (idx % 8)];
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [15:0] a, input logic [31:0] w);
    logic [15:0] p;
    p = a;
    mem[p] = w[31:24]; p = p + 16'd1;
    mem[p] = w[23:16]; p = p + 16'd1;
    mem[p] = w[15:8];  p = p + 16'd1;
    mem[p] = w[7:0];
  endtask

  int dv_cyc, dv_cnt, rises, fall, unstable;

  // Cycle 0 is the cycle with req=1 and busy=0; rel counts cycles from there.
  task automatic run_xfer(input logic [15:0] a, input bit pulse);
    int          rel;
    logic        prev_sck;
    logic [31:0] data0;
    logic [7:0]  ec;
    ec = EXP_CMD;
    dv_cyc = -1; dv_cnt = 0; rises = 0; fall = -1; unstable = 0;
    @(negedge clk12MHz);
    req = 1'b1; addr = a; rel = 0;
    prev_sck = spi_clk_out;
    data0 = data;
    while (rel < 2000 && fall < 0) begin
      @(negedge clk12MHz);
      rel++;
      req = pulse && (rel == 5 || rel == 100 || rel == 226);
      if (spi_clk_out && !prev_sck) rises++;
      prev_sck = spi_clk_out;
      if (rel == 1) begin
        check("busy_cycle1", 32'(busy), 32'd1);
        check("select_cycle1", 32'(spi_select), 32'd0);
        check("mosi_cycle1", 32'(spi_mosi), 32'(ec[7]));
      end
      if (data_valid) begin
        dv_cnt++;
        if (dv_cyc < 0) begin
          dv_cyc = rel;
          check("select_at_dv", 32'(spi_select), 32'd1);
          check("sck_at_dv", 32'(spi_clk_out), 32'd0);
        end
      end
      if (dv_cyc < 0 && data !== data0) unstable++;
      if (!busy) fall = rel;
    end
    req = 1'b0;
    if (fall < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL xfer_timeout: busy still high after %0d cycles, expected low by %0d", rel, EXP_FALL);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [31:0] mem_word;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int idle_rises;
    logic prev;

    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'hC3;

    vecs[0] = '{addr: 16'h1234, mem_word: 32'hDEADBEEF, exp_data: 32'hDEADBEEF};
    vecs[1] = '{addr: 16'hFFFE, mem_word: 32'h11223344, exp_data: 32'h11223344};
    vecs[2] = '{addr: 16'h0000, mem_word: 32'hA55A0FF0, exp_data: 32'hA55A0FF0};
    vecs[3] = '{addr: 16'h8001, mem_word: 32'h0180FF00, exp_data: 32'h0180FF00};

    // Test 1: reset and idle
    repeat (3) @(negedge clk12MHz);
    rst = 1'b0;
    idle_rises = 0;
    prev = spi_clk_out;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk12MHz);
      if (spi_clk_out && !prev) idle_rises++;
      prev = spi_clk_out;
    end
    check("idle_select", 32'(spi_select), 32'd1);
    check("idle_sck", 32'(spi_clk_out), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_data", data, 32'd0);
    check("idle_mosi", 32'(spi_mosi), 32'd0);
    check("idle_sck_edges", 32'(idle_rises), 32'd0);

    // Test 5: async reset in the middle of a transfer
    load_word(16'h1234, 32'hDEADBEEF);
    @(negedge clk12MHz);
    req = 1'b1; addr = 16'h1234;
    @(negedge clk12MHz);
    req = 1'b0;
    repeat (119) @(negedge clk12MHz);
    check("busy_before_rst", 32'(busy), 32'd1);
    check("sck_high_before_rst", 32'(spi_clk_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_select", 32'(spi_select), 32'd1);
    check("rst_async_sck", 32'(spi_clk_out), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_dv", 32'(data_valid), 32'd0);
    check("rst_async_mosi", 32'(spi_mosi), 32'd0);
    check("rst_async_data", data, 32'd0);
    repeat (3) @(negedge clk12MHz);
    rst = 1'b0;
    repeat (10) @(negedge clk12MHz);
    check("post_rst_data", data, 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Tests 2/3 and more: table of addresses and memory words
    for (int v = 0; v < 4; v++) begin
      load_word(vecs[v].addr, vecs[v].mem_word);
      run_xfer(vecs[v].addr, 1'b0);
      check("data", data, vecs[v].exp_data);
      check("cmd_on_mosi", 32'(m_cmd), 32'(EXP_CMD));
      check("addr_on_mosi", 32'(m_addr), 32'(vecs[v].addr));
      check("dv_cycle", 32'(dv_cyc), 32'(EXP_DV));
      check("dv_pulses", 32'(dv_cnt), 32'd1);
      check("busy_fall_cycle", 32'(fall), 32'(EXP_FALL));
      check("sck_rises", 32'(rises), 32'(EXP_RISES));
      check("data_no_partial", 32'(unstable), 32'd0);
      repeat (3) @(negedge clk12MHz);
    end

    // Test 4: req pulses while busy are ignored
    load_word(16'h4321, 32'hCAFEF00D);
    run_xfer(16'h4321, 1'b1);
    check("pulse_data", data, 32'hCAFEF00D);
    check("pulse_dv_cycle", 32'(dv_cyc), 32'(EXP_DV));
    check("pulse_dv_pulses", 32'(dv_cnt), 32'd1);
    check("pulse_sck_rises", 32'(rises), 32'(EXP_RISES));
    idle_rises = 0;
    prev = spi_clk_out;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk12MHz);
      if (spi_clk_out && !prev) idle_rises++;
      prev = spi_clk_out;
    end
    check("pulse_no_retrigger_busy", 32'(busy), 32'd0);
    check("pulse_no_retrigger_sck", 32'(idle_rises), 32'd0);

    // Held req re-triggers right when busy falls
    load_word(16'h0100, 32'h01234567);
    @(negedge clk12MHz);
    req = 1'b1; addr = 16'h0100;
    @(negedge clk12MHz);
    check("held_req_busy", 32'(busy), 32'd1);
    repeat (EXP_FALL - 1) @(negedge clk12MHz);
    check("held_req_busy_low", 32'(busy), 32'd0);
    @(negedge clk12MHz);
    check("held_req_retrigger", 32'(busy), 32'd1);
    req = 1'b0;
    repeat (EXP_FALL + 5) @(negedge clk12MHz);
    check("held_req_data", data, 32'h01234567);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
